// File: rtl/rob_commit_queue.sv
// Reorder buffer: in-order allocation, out-of-order writeback, in-order single-entry commit.
// Commit outputs are registered; status, forwarding and writeback-accept outputs are combinational.
module rob_commit_queue #(
  parameter int ROB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  input  logic                 dec_rdy,
  input  logic [4:0]           dec_rd,
  output logic                 dec_full,
  output logic [ROB_WIDTH-1:0] dec_rob_id,
  input  logic                 rs_rdy,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]          rs_data,
  output logic                 rs_en,
  input  logic [ROB_WIDTH-1:0] query_id,
  output logic                 query_ready,
  output logic [31:0]          query_data,
  output logic                 commit_en,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_data,
  output logic [ROB_WIDTH-1:0] commit_rob_id
);

  localparam int ROB_SIZE = 2 ** ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL_CNT = (ROB_WIDTH + 1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0]  present_q, present_d;
  logic [ROB_SIZE-1:0]  ready_q, ready_d;
  logic [4:0]           rd_q   [ROB_SIZE];
  logic [4:0]           rd_d   [ROB_SIZE];
  logic [31:0]          data_q [ROB_SIZE];
  logic [31:0]          data_d [ROB_SIZE];
  logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_WIDTH:0]   count_q, count_d;

  logic                 commit_en_q, commit_en_d;
  logic [4:0]           commit_rd_q, commit_rd_d;
  logic [31:0]          commit_data_q, commit_data_d;
  logic [ROB_WIDTH-1:0] commit_id_q, commit_id_d;

  logic active_s, alloc_s, wb_s, commit_s, bypass_s;

  assign active_s   = rdy_in & ~flush;
  assign dec_full   = (count_q == FULL_CNT);
  assign dec_rob_id = tail_q;
  assign rs_en      = active_s;
  assign alloc_s    = dec_rdy & ~dec_full & active_s;
  assign wb_s       = rs_rdy & active_s & present_q[rs_rob_id];
  // Commit looks only at stored ready, giving exactly one cycle from writeback to commit.
  assign commit_s   = active_s & present_q[head_q] & ready_q[head_q];

  // Operand forwarding with same-cycle bypass of an offered result.
  assign bypass_s    = rs_rdy & (rs_rob_id == query_id) & present_q[query_id];
  assign query_ready = bypass_s ? 1'b1 : ready_q[query_id];
  assign query_data  = bypass_s ? rs_data : data_q[query_id];

  assign commit_en     = commit_en_q;
  assign commit_rd     = commit_rd_q;
  assign commit_data   = commit_data_q;
  assign commit_rob_id = commit_id_q;

  // Next-state for entries and pointers; flush overrides every other update.
  always_comb begin
    present_d = present_q;
    ready_d   = ready_q;
    rd_d      = rd_q;
    data_d    = data_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (flush) begin
      present_d = '0;
      ready_d   = '0;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
    end else begin
      if (wb_s) begin
        ready_d[rs_rob_id] = 1'b1;
        data_d[rs_rob_id]  = rs_data;
      end
      if (commit_s) begin
        present_d[head_q] = 1'b0;
        ready_d[head_q]   = 1'b0;
        head_d            = head_q + ROB_WIDTH'(1);
      end
      if (alloc_s) begin
        present_d[tail_q] = 1'b1;
        ready_d[tail_q]   = 1'b0;
        rd_d[tail_q]      = dec_rd;
        tail_d            = tail_q + ROB_WIDTH'(1);
      end
      case ({alloc_s, commit_s})
        2'b10:   count_d = count_q + (ROB_WIDTH + 1)'(1);
        2'b01:   count_d = count_q - (ROB_WIDTH + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Commit pulse is one cycle; payload holds its last value between commits.
  always_comb begin
    commit_en_d   = commit_s;
    commit_rd_d   = commit_s ? rd_q[head_q]   : commit_rd_q;
    commit_data_d = commit_s ? data_q[head_q] : commit_data_q;
    commit_id_d   = commit_s ? head_q         : commit_id_q;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      present_q     <= '0;
      ready_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commit_en_q   <= 1'b0;
      commit_rd_q   <= 5'd0;
      commit_data_q <= 32'd0;
      commit_id_q   <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rd_q[i]   <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      present_q     <= present_d;
      ready_q       <= ready_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commit_en_q   <= commit_en_d;
      commit_rd_q   <= commit_rd_d;
      commit_data_q <= commit_data_d;
      commit_id_q   <= commit_id_d;
      rd_q          <= rd_d;
      data_q        <= data_d;
    end
  end

endmodule
